// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: handshake bundle between the packet sources, the arbiter and the UART TX
//   req_data  [8*NUM_REQ] : payload byte of requester i in [8i+7:8i]
//   req_valid [NUM_REQ]   : per-requester byte valid
//   req_last  [NUM_REQ]   : per-requester final-payload-byte marker
//   req_ready [NUM_REQ]   : per-requester byte accepted
//   tx_data/tx_valid      : byte stream towards the UART TX
//   tx_ready              : UART TX can take a byte
//   busy/grant_id         : frame in progress, current or last granted requester
//   master modport = arbiter side, slave modport = sources/UART side
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;
    logic [3:0]           grant_id;
    modport master (
        input  req_data, req_valid, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, busy, grant_id
    );
    modport slave (
        output req_data, req_valid, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX byte stream among NUM_REQ packet sources
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : uart_tx_arbiter_if.master (requester streams in, framed byte stream out, busy, grant_id)
// Each granted packet is sent as SOF, {4'h0,id}, payload, [checksum], EOF.
// Define UART_ARB_CHECKSUM_EN to add the two's-complement checksum byte before EOF.
module uart_tx_arbiter #(
    parameter int         NUM_REQ  = 4,
    parameter logic [7:0] SOF_BYTE = 8'hA5,
    parameter logic [7:0] EOF_BYTE = 8'h5A
) (
    input logic               clk,
    input logic               reset,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        SOF,
        HDR,
        PAY,
`ifdef UART_ARB_CHECKSUM_EN
        CHK,
`endif
        EOF
    } state_t;

    state_t     r_state;
    logic [3:0] r_rr_ptr;
    logic [3:0] r_grant;
`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0] r_csum;
`endif
    logic       w_found;
    logic [3:0] w_pick;
    logic [7:0] w_pay_data;
    logic       w_pay_vld;
    logic       w_pay_last;
    logic       w_fire;

    // First pass looks strictly above the pointer; if nothing is found the lowest
    // valid index overall is the wrapped-around winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && bus.req_valid[k] && 4'(k) > r_rr_ptr) begin
                w_found = 1'b1;
                w_pick  = 4'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && bus.req_valid[k]) begin
                w_found = 1'b1;
                w_pick  = 4'(k);
            end
        end
    end

    always_comb begin
        w_pay_data = '0;
        w_pay_vld  = 1'b0;
        w_pay_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant == 4'(k)) begin
                w_pay_data = bus.req_data[8*k +: 8];
                w_pay_vld  = bus.req_valid[k];
                w_pay_last = bus.req_last[k];
            end
        end
    end

    // Only tx_ready feeds req_ready combinationally; tx_valid never depends on tx_ready.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++)
            bus.req_ready[k] = (r_state == PAY) && (r_grant == 4'(k)) && bus.tx_ready;
    end

    always_comb begin
        case (r_state)
            SOF:     bus.tx_data = SOF_BYTE;
            HDR:     bus.tx_data = {4'h0, r_grant};
            PAY:     bus.tx_data = w_pay_data;
`ifdef UART_ARB_CHECKSUM_EN
            CHK:     bus.tx_data = ~r_csum + 8'd1;
`endif
            EOF:     bus.tx_data = EOF_BYTE;
            default: bus.tx_data = '0;
        endcase
    end

    assign bus.tx_valid = (r_state == PAY) ? w_pay_vld : (r_state != IDLE);
    assign w_fire       = bus.tx_valid && bus.tx_ready;
    assign bus.busy     = (r_state != IDLE);
    assign bus.grant_id = r_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= 4'(NUM_REQ - 1);
            r_grant  <= '0;
`ifdef UART_ARB_CHECKSUM_EN
            r_csum   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_grant  <= w_pick;
                    r_rr_ptr <= w_pick;
                    r_state  <= SOF;
                end
                SOF: if (w_fire) r_state <= HDR;
                HDR: if (w_fire) begin
`ifdef UART_ARB_CHECKSUM_EN
                    r_csum  <= {4'h0, r_grant};
`endif
                    r_state <= PAY;
                end
                PAY: if (w_fire) begin
`ifdef UART_ARB_CHECKSUM_EN
                    r_csum <= r_csum + w_pay_data;
                    if (w_pay_last) r_state <= CHK;
`else
                    if (w_pay_last) r_state <= EOF;
`endif
                end
`ifdef UART_ARB_CHECKSUM_EN
                CHK: if (w_fire) r_state <= EOF;
`endif
                EOF: if (w_fire) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table vectors, directed corner sequences and a randomized frame-level model
module tb_uart_tx_arbiter;
    localparam int N    = 4;
    localparam int BAUD = 17;
`ifdef UART_ARB_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] vld;
        logic [7:0] d;
        logic       last;
        logic       txr;
        logic       e_busy;
        logic       e_tv;
        logic [7:0] e_td;
        logic [3:0] e_rr;
    } vec_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] cap[$];
    logic [8:0] dq[N][$];
    logic [8:0] mq[N][$];
    vec_t       tbl[$];

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
    uart_tx_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk)
        if (reset && bus.tx_valid && bus.tx_ready) cap.push_back(bus.tx_data);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        cap.delete();
    endtask

    task automatic rand_run(input bit baud_mode);
        logic [7:0] eq[$];
        logic [8:0] x;
        logic [3:0] v, rr, fire, held;
        logic [7:0] prev_td, b;
        bit         pend, prev_stall, done, lst;
        int         last_g, cur_g, g, sum, len, left;
        do_reset();
        for (int r = 0; r < N; r++) begin
            dq[r].delete();
            mq[r].delete();
            for (int p = 0; p < 3; p++) begin
                len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) begin
                    b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
                    dq[r].push_back({i == len - 1, b});
                    mq[r].push_back({i == len - 1, b});
                end
            end
        end
        last_g = N - 1; cur_g = 0; pend = 0; prev_stall = 0; prev_td = '0; done = 0; held = '0;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            for (int r = 0; r < N; r++) begin
                if (dq[r].size() > 0) begin
                    bus.req_valid[r]      = held[r] || ($urandom_range(0, 3) != 0);
                    bus.req_data[8*r +: 8] = dq[r][0][7:0];
                    bus.req_last[r]       = dq[r][0][8];
                end else begin
                    bus.req_valid[r] = 1'b0;
                    bus.req_last[r]  = 1'b0;
                end
            end
            bus.tx_ready = baud_mode ? (cyc % BAUD == 0) : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            v  = bus.req_valid;
            rr = bus.req_ready;
            if (pend) begin
                check("rnd_busy", bus.busy, 1);
                check("rnd_grant", bus.grant_id, cur_g);
                pend = 0;
            end
            if (!bus.busy) begin
                check("rnd_idle_ready", rr, 0);
                if (v != 0) begin
                    g = -1;
                    for (int k = 1; k <= N; k++)
                        if (g < 0 && v[(last_g + k) % N]) g = (last_g + k) % N;
                    eq.push_back(8'hA5);
                    eq.push_back(8'(g));
                    sum = g;
                    lst = 0;
                    while (!lst && mq[g].size() > 0) begin
                        x = mq[g].pop_front();
                        eq.push_back(x[7:0]);
                        sum += x[7:0];
                        lst = x[8];
                    end
                    if (CHK_EN) eq.push_back(8'(256 - sum % 256));
                    eq.push_back(8'h5A);
                    last_g = g; cur_g = g; pend = 1;
                end
            end else begin
                check("rnd_other_ready", rr & ~(4'b1 << cur_g), 0);
            end
            if (prev_stall) begin
                check("hold_valid", bus.tx_valid, 1);
                check("hold_data", bus.tx_data, prev_td);
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_td    = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                if (eq.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL rnd_extra: got byte %0h, want none", bus.tx_data);
                end else check("rnd_byte", bus.tx_data, eq.pop_front());
            end
            fire = v & rr;
            held = v & ~rr;
            left = 0;
            for (int r = 0; r < N; r++) left += dq[r].size();
            done = (left == 0) && (eq.size() == 0) && !bus.busy && !pend;
            @(posedge clk);
            #1;
            for (int r = 0; r < N; r++)
                if (fire[r] && dq[r].size() > 0) x = dq[r].pop_front();
        end
        left = 0;
        for (int r = 0; r < N; r++) left += mq[r].size();
        check("rnd_done", done, 1);
        check("rnd_model_left", left, 0);
        idle_inputs();
    endtask

    initial begin
        logic [7:0] ex[$];
        int         got[$], gaps[$];
        int         gap, p, cyc;
        bit         pb, seen;

        tbl.push_back('{4'b0100, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000});
        tbl.push_back('{4'b0100, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 4'b0000});
        tbl.push_back('{4'b0100, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 4'b0000});
        tbl.push_back('{4'b0100, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 4'b0000});
        tbl.push_back('{4'b0100, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'b0000});
        tbl.push_back('{4'b0100, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 4'b0100});
        tbl.push_back('{4'b0100, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 4'b0100});
`ifdef UART_ARB_CHECKSUM_EN
        tbl.push_back('{4'b0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hCB, 4'b0000});
`endif
        tbl.push_back('{4'b0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 4'b0000});
        tbl.push_back('{4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000});

        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_grant", bus.grant_id, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        foreach (tbl[i]) begin
            bus.req_valid        = tbl[i].vld;
            bus.req_data         = '0;
            bus.req_data[23:16]  = tbl[i].d;
            bus.req_last         = {1'b0, tbl[i].last, 2'b00};
            bus.tx_ready         = tbl[i].txr;
            @(negedge clk);
            check($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_tx_valid", i), bus.tx_valid, tbl[i].e_tv);
            check($sformatf("tbl%0d_req_ready", i), bus.req_ready, tbl[i].e_rr);
            if (tbl[i].e_tv) check($sformatf("tbl%0d_tx_data", i), bus.tx_data, tbl[i].e_td);
            @(posedge clk);
            #1;
        end
        check("tbl_grant_hold", bus.grant_id, 2);

        do_reset();
        bus.req_valid = 4'hF;
        bus.req_last  = 4'hF;
        bus.req_data  = 32'h43424140;
        gap = 0; pb = 0;
        for (cyc = 0; cyc < 200 && got.size() < 5; cyc++) begin
            @(negedge clk);
            if (bus.busy && !pb) begin
                got.push_back(int'(bus.grant_id));
                gaps.push_back(gap);
            end
            gap = bus.busy ? 0 : gap + 1;
            pb  = bus.busy;
            @(posedge clk);
            #1;
        end
        check("rr_count", got.size(), 5);
        p = N - 1;
        foreach (got[i]) begin
            p = (p + 1) % N;
            check($sformatf("rr_order%0d", i), got[i], p);
            check($sformatf("rr_gap%0d", i), gaps[i], 1);
        end

        do_reset();
        bus.req_valid       = 4'b0010;
        bus.req_data[15:8]  = 8'h10;
        repeat (4) @(posedge clk);
        #1;
        bus.req_valid       = 4'b1001;
        bus.req_data        = 32'h77002077;
        bus.req_last        = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_tv%0d", i), bus.tx_valid, 0);
            check($sformatf("stall_others%0d", i), bus.req_ready & 4'b1101, 0);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 4'b0010;
        @(posedge clk);
        #1 bus.req_valid = 4'b0000;
        repeat (4) @(posedge clk);
        #1;
        ex = '{8'hA5, 8'h01, 8'h10, 8'h20};
        if (CHK_EN) ex.push_back(8'hCF);
        ex.push_back(8'h5A);
        check("stall_len", cap.size(), ex.size());
        foreach (ex[i]) if (i < cap.size()) check($sformatf("stall_byte%0d", i), cap[i], ex[i]);

        do_reset();
        bus.req_valid      = 4'b0010;
        bus.req_data[15:8] = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_tv", bus.tx_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("async_tv", bus.tx_valid, 0);
        check("async_ready", bus.req_ready, 0);
        check("async_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cap.delete();
        bus.req_valid = 4'hF;
        bus.req_last  = 4'hF;
        bus.req_data  = 32'h43424140;
        seen = 0;
        for (cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (bus.busy) begin
                seen = 1;
                check("post_rst_grant", bus.grant_id, 0);
            end
            @(posedge clk);
            #1;
        end
        check("post_rst_seen", seen, 1);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_cap", cap.size() >= 2, 1);
        if (cap.size() >= 2) begin
            check("post_rst_sof", cap[0], 8'hA5);
            check("post_rst_hdr", cap[1], 8'h00);
        end

        rand_run(1'b0);
        rand_run(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
